dispatch_scheduler: RTL and testbench

//  In-order dispatch controller between the instruction fetch queue (IFQ)/decoder and the four issue queues.

---
 rtl/dispatch_scheduler_pkg.sv | 44 ++++
 rtl/dispatch_scheduler_if.sv | 57 +++++
 rtl/dispatch_scheduler_reg_status_table.sv | 47 ++++
 rtl/dispatch_scheduler.sv | 110 +++++++++++
 tb/tb_dispatch_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_scheduler_pkg.sv
// Shared types and constants for the dispatch scheduler: opcodes, queue select, RST entry.
package dispatch_scheduler_pkg;

    localparam int NUM_TAGS = 16;
    localparam int NUM_REGS = 32;
    localparam int TAG_W    = $clog2(NUM_TAGS);
    localparam int REG_W    = $clog2(NUM_REGS);

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] B_TYPE = 7'b1100011;

    // Bit order matches q_full: {div, mult, ldst, int}.
    typedef enum logic [3:0] {
        SEL_NONE = 4'b0000,
        SEL_INT  = 4'b0001,
        SEL_LDST = 4'b0010,
        SEL_MULT = 4'b0100,
        SEL_DIV  = 4'b1000
    } queue_sel_e;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rst_entry_t;

    function automatic queue_sel_e classify(input logic [6:0] opcode,
                                            input logic       func3_msb,
                                            input logic [6:0] func7);
        if (opcode == LW || opcode == S_TYPE) return SEL_LDST;
        if (opcode == R_TYPE && func7 == 7'b0000001) return func3_msb ? SEL_DIV : SEL_MULT;
        return SEL_INT;
    endfunction

    function automatic logic [TAG_W:0] count_ones(input logic [NUM_TAGS-1:0] v);
        logic [TAG_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_TAGS; i++) n = n + {{TAG_W{1'b0}}, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/dispatch_scheduler_if.sv
// Bundle of IFQ, issue-queue, dispatch-bus and CDB signals. Perf outputs exist only with DISPATCH_PERF_EN.
interface dispatch_scheduler_if;
    import dispatch_scheduler_pkg::*;

    logic             ifq_empty;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             rd_en;
    logic             ifq_rd_en;
    logic [3:0]       q_full;
    logic [3:0]       disp_sel;
    logic [TAG_W-1:0] disp_tag;
    logic             disp_rs1_busy;
    logic             disp_rs2_busy;
    logic [TAG_W-1:0] disp_rs1_tag;
    logic [TAG_W-1:0] disp_rs2_tag;
    logic [4:0]       disp_rd;
    logic             disp_rd_en;
    logic [6:0]       disp_opcode;
    logic [2:0]       disp_func3;
    logic [6:0]       disp_func7;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             flush;
    logic [TAG_W:0]   tags_free;
`ifdef DISPATCH_PERF_EN
    logic [31:0]      perf_disp_cnt;
    logic [31:0]      perf_stall_cnt;
`endif

    modport master (
        output ifq_empty, opcode, func3, func7, rs1, rs2, rd, rd_en, q_full,
               cdb_valid, cdb_tag, flush,
        input  ifq_rd_en, disp_sel, disp_tag, disp_rs1_busy, disp_rs2_busy,
               disp_rs1_tag, disp_rs2_tag, disp_rd, disp_rd_en, disp_opcode,
               disp_func3, disp_func7, tags_free
`ifdef DISPATCH_PERF_EN
        , input perf_disp_cnt, perf_stall_cnt
`endif
    );

    modport slave (
        input  ifq_empty, opcode, func3, func7, rs1, rs2, rd, rd_en, q_full,
               cdb_valid, cdb_tag, flush,
        output ifq_rd_en, disp_sel, disp_tag, disp_rs1_busy, disp_rs2_busy,
               disp_rs1_tag, disp_rs2_tag, disp_rd, disp_rd_en, disp_opcode,
               disp_func3, disp_func7, tags_free
`ifdef DISPATCH_PERF_EN
        , output perf_disp_cnt, perf_stall_cnt
`endif
    );

endinterface

// File: rtl/dispatch_scheduler_reg_status_table.sv
// Register status table: per-register {busy, tag}, two bypassed read ports, one write port, CDB clear.
module dispatch_scheduler_reg_status_table
    import dispatch_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output rst_entry_t       src1,
    output rst_entry_t       src2,
    input  logic             clr_valid,
    input  logic [TAG_W-1:0] clr_tag,
    input  logic             wr_en,
    input  logic [REG_W-1:0] wr_reg,
    input  logic [TAG_W-1:0] wr_tag
);

    rst_entry_t table_q [NUM_REGS];

    // A source is ready if it is x0, not busy, or its producer is on the CDB right now.
    function automatic rst_entry_t resolve(input logic [REG_W-1:0] r, input rst_entry_t e,
                                           input logic cv, input logic [TAG_W-1:0] ct);
        if (r == '0 || !e.busy || (cv && ct == e.tag)) return '0;
        return e;
    endfunction

    always_comb begin
        src1 = resolve(rs1, table_q[rs1], clr_valid, clr_tag);
        src2 = resolve(rs2, table_q[rs2], clr_valid, clr_tag);
    end

    // NOTE: the table is small and its busy bits are architectural state, so every entry is
    // reset (and cleared on flush); non-blocking writes let the later dispatch write override the CDB clear.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_REGS; i++) table_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_valid && table_q[i].busy && table_q[i].tag == clr_tag)
                    table_q[i].busy <= 1'b0;
            end
            if (wr_en && wr_reg != '0) table_q[wr_reg] <= {1'b1, wr_tag};
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order dispatch controller: classify, allocate tag, rename via RST, drive registered dispatch bus.
// Optional DISPATCH_PERF_EN adds dispatch and stall counters.
module dispatch_scheduler
    import dispatch_scheduler_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    dispatch_scheduler_if.slave bus
);

    queue_sel_e          target;
    logic [NUM_TAGS-1:0] free_q;
    logic [NUM_TAGS-1:0] free_d;
    logic [TAG_W-1:0]    alloc_tag;
    logic                fire;
    logic                cdb_hit;
    rst_entry_t          src1;
    rst_entry_t          src2;

    assign target  = classify(bus.opcode, bus.func3[2], bus.func7);
    assign fire    = !rst && !bus.ifq_empty && !(|(bus.q_full & 4'(target)))
                     && (|free_q) && !bus.flush;
    // CDB only matters for tags that are actually in flight, and never during flush.
    assign cdb_hit = bus.cdb_valid && !free_q[bus.cdb_tag] && !bus.flush;
    assign bus.ifq_rd_en = fire;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_tag = TAG_W'(i);
        end
    end

    always_comb begin
        free_d = free_q;
        if (cdb_hit) free_d[bus.cdb_tag] = 1'b1;
        if (fire)    free_d[alloc_tag]   = 1'b0;
        if (bus.flush) free_d = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q        <= '1;
            bus.tags_free <= (TAG_W + 1)'(NUM_TAGS);
        end else begin
            free_q        <= free_d;
            bus.tags_free <= count_ones(free_d);
        end
    end

    dispatch_scheduler_reg_status_table u_reg_status_table (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .rs1       (bus.rs1),
        .rs2       (bus.rs2),
        .src1      (src1),
        .src2      (src2),
        .clr_valid (cdb_hit),
        .clr_tag   (bus.cdb_tag),
        .wr_en     (fire && bus.rd_en),
        .wr_reg    (bus.rd),
        .wr_tag    (alloc_tag)
    );

    // Dispatch bus: disp_sel pulses for one cycle; payload holds until the next dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.disp_sel      <= SEL_NONE;
            bus.disp_tag      <= '0;
            bus.disp_rs1_busy <= 1'b0;
            bus.disp_rs2_busy <= 1'b0;
            bus.disp_rs1_tag  <= '0;
            bus.disp_rs2_tag  <= '0;
            bus.disp_rd       <= '0;
            bus.disp_rd_en    <= 1'b0;
            bus.disp_opcode   <= '0;
            bus.disp_func3    <= '0;
            bus.disp_func7    <= '0;
        end else begin
            bus.disp_sel <= fire ? target : SEL_NONE;
            if (fire) begin
                bus.disp_tag      <= alloc_tag;
                bus.disp_rs1_busy <= src1.busy;
                bus.disp_rs2_busy <= src2.busy;
                bus.disp_rs1_tag  <= src1.tag;
                bus.disp_rs2_tag  <= src2.tag;
                bus.disp_rd       <= bus.rd;
                bus.disp_rd_en    <= bus.rd_en;
                bus.disp_opcode   <= bus.opcode;
                bus.disp_func3    <= bus.func3;
                bus.disp_func7    <= bus.func7;
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.perf_disp_cnt  <= '0;
            bus.perf_stall_cnt <= '0;
        end else begin
            if (fire) bus.perf_disp_cnt <= bus.perf_disp_cnt + 32'd1;
            if (!bus.ifq_empty && !fire) bus.perf_stall_cnt <= bus.perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed testbench for dispatch_scheduler: reset, rename, tag exhaustion, queue stall, CDB bypass, flush.
module tb_dispatch_scheduler;
    import dispatch_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    dispatch_scheduler_if bus ();

    dispatch_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ifq_empty = 1'b1;
        bus.opcode = '0; bus.func3 = '0; bus.func7 = '0;
        bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.rd_en = 1'b0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic de);
        bus.ifq_empty = 1'b0;
        bus.opcode = op; bus.func3 = f3; bus.func7 = f7;
        bus.rs1 = s1; bus.rs2 = s2; bus.rd = d; bus.rd_en = de;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        bus.q_full = '0; bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.flush = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (bus.tags_free !== 5'd16) $display("FAIL rst_tags_free: got %0d want 16", bus.tags_free); else pass_cnt++;
        total_cnt++; if (bus.disp_sel !== 4'b0000) $display("FAIL rst_sel: got %b want 0000", bus.disp_sel); else pass_cnt++;
`ifdef DISPATCH_PERF_EN
        total_cnt++; if (bus.perf_disp_cnt !== 32'd0) $display("FAIL rst_perf_disp: got %0d want 0", bus.perf_disp_cnt); else pass_cnt++;
        total_cnt++; if (bus.perf_stall_cnt !== 32'd0) $display("FAIL rst_perf_stall: got %0d want 0", bus.perf_stall_cnt); else pass_cnt++;
`endif
        drive(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        cyc();
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.ifq_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b want 0", bus.ifq_rd_en); else pass_cnt++;
        cyc();
        total_cnt++; if (bus.disp_rd !== 5'd0) $display("FAIL rst_disp_rd: got %0d want 0", bus.disp_rd); else pass_cnt++;
        total_cnt++; if (bus.disp_rd_en !== 1'b0) $display("FAIL rst_disp_rd_en: got %b want 0", bus.disp_rd_en); else pass_cnt++;
        total_cnt++; if (bus.tags_free !== 5'd16) $display("FAIL rst_tags_after: got %0d want 16", bus.tags_free); else pass_cnt++;
        rst = 1'b0;
        idle();
    endtask

    task automatic test_basic();
        do_reset();
        drive(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        #1;
        total_cnt++; if (bus.ifq_rd_en !== 1'b1) $display("FAIL basic_rd_en: got %b want 1", bus.ifq_rd_en); else pass_cnt++;
        cyc();
        drive(I_TYPE, 3'd0, 7'd0, 5'd3, 5'd0, 5'd4, 1'b1);
        total_cnt++; if (bus.disp_sel !== 4'b0001) $display("FAIL basic_sel: got %b want 0001", bus.disp_sel); else pass_cnt++;
        total_cnt++; if (bus.disp_tag !== 4'd0) $display("FAIL basic_tag: got %0d want 0", bus.disp_tag); else pass_cnt++;
        total_cnt++; if ({bus.disp_rs1_busy, bus.disp_rs2_busy} !== 2'b00) $display("FAIL basic_busy: got %b want 00", {bus.disp_rs1_busy, bus.disp_rs2_busy}); else pass_cnt++;
        total_cnt++; if (bus.tags_free !== 5'd15) $display("FAIL basic_tags_free: got %0d want 15", bus.tags_free); else pass_cnt++;
        total_cnt++; if (bus.disp_rd !== 5'd3) $display("FAIL basic_rd: got %0d want 3", bus.disp_rd); else pass_cnt++;
        cyc();
        idle();
        total_cnt++; if (bus.disp_rs1_busy !== 1'b1 || bus.disp_rs1_tag !== 4'd0) $display("FAIL basic_rst_x3: got busy %b tag %0d want busy 1 tag 0", bus.disp_rs1_busy, bus.disp_rs1_tag); else pass_cnt++;
        total_cnt++; if (bus.disp_tag !== 4'd1) $display("FAIL basic_tag2: got %0d want 1", bus.disp_tag); else pass_cnt++;
        total_cnt++; if (bus.disp_opcode !== I_TYPE) $display("FAIL basic_opcode: got %b want %b", bus.disp_opcode, I_TYPE); else pass_cnt++;
        cyc();
        total_cnt++; if (bus.disp_sel !== 4'b0000) $display("FAIL basic_sel_pulse: got %b want 0000", bus.disp_sel); else pass_cnt++;
    endtask

    task automatic test_mul_dep();
        do_reset();
        drive(R_TYPE, 3'd0, 7'd1, 5'd1, 5'd2, 5'd5, 1'b1);
        cyc();
        drive(R_TYPE, 3'd0, 7'd0, 5'd5, 5'd0, 5'd6, 1'b1);
        total_cnt++; if (bus.disp_sel !== 4'b0100) $display("FAIL mul_sel: got %b want 0100", bus.disp_sel); else pass_cnt++;
        cyc();
        drive(R_TYPE, 3'd4, 7'd1, 5'd6, 5'd5, 5'd7, 1'b1);
        total_cnt++; if (bus.disp_sel !== 4'b0001) $display("FAIL dep_sel: got %b want 0001", bus.disp_sel); else pass_cnt++;
        total_cnt++; if (bus.disp_rs1_busy !== 1'b1 || bus.disp_rs1_tag !== 4'd0) $display("FAIL dep_rs1: got busy %b tag %0d want busy 1 tag 0", bus.disp_rs1_busy, bus.disp_rs1_tag); else pass_cnt++;
        total_cnt++; if (bus.disp_rs2_busy !== 1'b0) $display("FAIL dep_rs2_x0: got %b want 0", bus.disp_rs2_busy); else pass_cnt++;
        cyc();
        drive(R_TYPE, 3'd4, 7'd0, 5'd1, 5'd2, 5'd8, 1'b1);
        total_cnt++; if (bus.disp_sel !== 4'b1000) $display("FAIL div_sel: got %b want 1000", bus.disp_sel); else pass_cnt++;
        total_cnt++; if ({bus.disp_rs1_busy, bus.disp_rs1_tag, bus.disp_rs2_busy, bus.disp_rs2_tag} !== {1'b1, 4'd1, 1'b1, 4'd0}) $display("FAIL div_srcs: got %b/%0d %b/%0d want 1/1 1/0", bus.disp_rs1_busy, bus.disp_rs1_tag, bus.disp_rs2_busy, bus.disp_rs2_tag); else pass_cnt++;
        total_cnt++; if (bus.disp_tag !== 4'd2) $display("FAIL div_tag: got %0d want 2", bus.disp_tag); else pass_cnt++;
        cyc();
        idle();
        total_cnt++; if (bus.disp_sel !== 4'b0001) $display("FAIL xor_sel: got %b want 0001", bus.disp_sel); else pass_cnt++;
    endtask

    task automatic test_tag_exhaust();
        do_reset();
        drive(I_TYPE, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 16; i++) cyc();
        total_cnt++; if (bus.disp_tag !== 4'd15) $display("FAIL exh_last_tag: got %0d want 15", bus.disp_tag); else pass_cnt++;
        total_cnt++; if (bus.tags_free !== 5'd0) $display("FAIL exh_tags_free: got %0d want 0", bus.tags_free); else pass_cnt++;
        total_cnt++; if (bus.ifq_rd_en !== 1'b0) $display("FAIL exh_rd_en: got %b want 0", bus.ifq_rd_en); else pass_cnt++;
        cyc();
        total_cnt++; if (bus.disp_sel !== 4'b0000) $display("FAIL exh_stall_sel: got %b want 0000", bus.disp_sel); else pass_cnt++;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd3;
        #1;
        total_cnt++; if (bus.ifq_rd_en !== 1'b0) $display("FAIL exh_cdb_same: got %b want 0", bus.ifq_rd_en); else pass_cnt++;
        cyc();
        bus.cdb_valid = 1'b0;
        #1;
        total_cnt++; if (bus.ifq_rd_en !== 1'b1) $display("FAIL exh_refire: got %b want 1", bus.ifq_rd_en); else pass_cnt++;
        total_cnt++; if (bus.tags_free !== 5'd1) $display("FAIL exh_freed: got %0d want 1", bus.tags_free); else pass_cnt++;
        cyc();
        total_cnt++; if (bus.disp_sel !== 4'b0001 || bus.disp_tag !== 4'd3) $display("FAIL exh_tag3: got sel %b tag %0d want 0001 tag 3", bus.disp_sel, bus.disp_tag); else pass_cnt++;
        total_cnt++; if (bus.ifq_rd_en !== 1'b0) $display("FAIL exh_restall: got %b want 0", bus.ifq_rd_en); else pass_cnt++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle();
        total_cnt++; if (bus.tags_free !== 5'd16 || bus.disp_sel !== 4'b0000) $display("FAIL exh_rst_mid_stall: got free %0d sel %b want 16 0000", bus.tags_free, bus.disp_sel); else pass_cnt++;
    endtask

    task automatic test_queue_full();
        do_reset();
        bus.q_full = 4'b0010;
        drive(LW, 3'd2, 7'd0, 5'd1, 5'd0, 5'd8, 1'b1);
        #1;
        total_cnt++; if (bus.ifq_rd_en !== 1'b0) $display("FAIL qf_rd_en: got %b want 0", bus.ifq_rd_en); else pass_cnt++;
        cyc(); cyc();
        total_cnt++; if (bus.disp_sel !== 4'b0000 || bus.tags_free !== 5'd16) $display("FAIL qf_held: got sel %b free %0d want 0000 16", bus.disp_sel, bus.tags_free); else pass_cnt++;
        bus.q_full = 4'b0001;
        #1;
        total_cnt++; if (bus.ifq_rd_en !== 1'b1) $display("FAIL qf_release: got %b want 1", bus.ifq_rd_en); else pass_cnt++;
        cyc();
        drive(R_TYPE, 3'd0, 7'd0, 5'd8, 5'd0, 5'd9, 1'b1);
        total_cnt++; if (bus.disp_sel !== 4'b0010 || bus.disp_tag !== 4'd0 || bus.disp_rd !== 5'd8) $display("FAIL qf_lw: got sel %b tag %0d rd %0d want 0010 0 8", bus.disp_sel, bus.disp_tag, bus.disp_rd); else pass_cnt++;
        #1;
        total_cnt++; if (bus.ifq_rd_en !== 1'b0) $display("FAIL qf_int_full: got %b want 0", bus.ifq_rd_en); else pass_cnt++;
        cyc();
        total_cnt++; if (bus.disp_sel !== 4'b0000) $display("FAIL qf_int_stall: got %b want 0000", bus.disp_sel); else pass_cnt++;
        bus.q_full = 4'b0000;
        cyc();
        drive(S_TYPE, 3'd2, 7'd0, 5'd9, 5'd8, 5'd0, 1'b0);
        total_cnt++; if (bus.disp_sel !== 4'b0001 || bus.disp_tag !== 4'd1 || bus.disp_rs1_busy !== 1'b1 || bus.disp_rs1_tag !== 4'd0) $display("FAIL qf_order: got sel %b tag %0d rs1 %b/%0d want 0001 1 1/0", bus.disp_sel, bus.disp_tag, bus.disp_rs1_busy, bus.disp_rs1_tag); else pass_cnt++;
        cyc();
        idle();
        total_cnt++; if (bus.disp_sel !== 4'b0010 || bus.disp_tag !== 4'd2) $display("FAIL qf_store: got sel %b tag %0d want 0010 2", bus.disp_sel, bus.disp_tag); else pass_cnt++;
    endtask

    task automatic test_cdb_bypass();
        do_reset();
        drive(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        cyc();
        drive(R_TYPE, 3'd0, 7'd0, 5'd3, 5'd3, 5'd3, 1'b1);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd0;
        cyc();
        bus.cdb_valid = 1'b0;
        drive(I_TYPE, 3'd0, 7'd0, 5'd3, 5'd0, 5'd4, 1'b1);
        total_cnt++; if ({bus.disp_rs1_busy, bus.disp_rs2_busy} !== 2'b00) $display("FAIL byp_busy: got %b want 00", {bus.disp_rs1_busy, bus.disp_rs2_busy}); else pass_cnt++;
        total_cnt++; if (bus.disp_tag !== 4'd1 || bus.tags_free !== 5'd15) $display("FAIL byp_tag: got tag %0d free %0d want 1 15", bus.disp_tag, bus.tags_free); else pass_cnt++;
        cyc();
        idle();
        total_cnt++; if (bus.disp_rs1_busy !== 1'b1 || bus.disp_rs1_tag !== 4'd1) $display("FAIL byp_new_map: got busy %b tag %0d want 1 1", bus.disp_rs1_busy, bus.disp_rs1_tag); else pass_cnt++;
        total_cnt++; if (bus.disp_tag !== 4'd0) $display("FAIL byp_realloc: got %0d want 0", bus.disp_tag); else pass_cnt++;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd9;
        cyc();
        bus.cdb_valid = 1'b0;
        total_cnt++; if (bus.tags_free !== 5'd14) $display("FAIL byp_unalloc_cdb: got %0d want 14", bus.tags_free); else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(R_TYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'(k), 1'b1);
            cyc();
        end
        total_cnt++; if (bus.tags_free !== 5'd11) $display("FAIL fl_pre_free: got %0d want 11", bus.tags_free); else pass_cnt++;
        drive(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd2, 5'd6, 1'b1);
        bus.flush = 1'b1; bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd0;
        #1;
        total_cnt++; if (bus.ifq_rd_en !== 1'b0) $display("FAIL fl_rd_en: got %b want 0", bus.ifq_rd_en); else pass_cnt++;
        cyc();
        bus.flush = 1'b0; bus.cdb_valid = 1'b0;
        drive(R_TYPE, 3'd0, 7'd0, 5'd1, 5'd5, 5'd7, 1'b1);
        total_cnt++; if (bus.disp_sel !== 4'b0000 || bus.tags_free !== 5'd16) $display("FAIL fl_after: got sel %b free %0d want 0000 16", bus.disp_sel, bus.tags_free); else pass_cnt++;
        cyc();
        idle();
        total_cnt++; if ({bus.disp_rs1_busy, bus.disp_rs2_busy} !== 2'b00) $display("FAIL fl_srcs: got %b want 00", {bus.disp_rs1_busy, bus.disp_rs2_busy}); else pass_cnt++;
        total_cnt++; if (bus.disp_tag !== 4'd0 || bus.tags_free !== 5'd15) $display("FAIL fl_new_tag: got tag %0d free %0d want 0 15", bus.disp_tag, bus.tags_free); else pass_cnt++;
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mul_dep();
        test_tag_exhaust();
        test_queue_full();
        test_cdb_bypass();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
